// File: rtl/id_ex_mem_pipe_pkg.sv
// id_ex_mem_pipe_pkg: widths, branch opcode/rt codes and d_ctrl field offsets for the D/E/M slice
package id_ex_mem_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 24;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;
  localparam int C_ALUBSEL = 0;
  localparam int C_ERESULTSEL = 1;
  localparam int C_MDUEN = 3;
  localparam int C_DMWE = 4;
  localparam int C_DATAWBSEL = 5;
  localparam int C_REGWE = 6;
  localparam int C_ALUCTRL = 7;
  localparam int C_SLCTRL = 15;
  localparam int C_MDUCTRL = 18;
endpackage

// File: rtl/id_ex_mem_pipe_branch_cmp.sv
// branch_cmp: combinational signed branch resolver (rd1/rd2/rt/opcode/isbr -> br); BRANCH_LINK_EN adds bltzal/bgezal
module branch_cmp
  import id_ex_mem_pipe_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic [DW-1:0] rd1_i,
  input  logic [DW-1:0] rd2_i,
  input  logic [4:0]    rt_i,
  input  logic [5:0]    opcode_i,
  input  logic          isbr_i,
  output logic          br_o
);
  logic eq, neg, zero, link, regimm, cond;
  assign eq = rd1_i == rd2_i;
  assign neg = rd1_i[DW-1];
  assign zero = rd1_i == '0;
`ifdef BRANCH_LINK_EN
  assign link = rt_i == RT_BLTZAL ? neg : rt_i == RT_BGEZAL ? !neg : 1'b0;
`else
  assign link = 1'b0;
`endif
  always_comb begin
    regimm = rt_i == RT_BLTZ ? neg : rt_i == RT_BGEZ ? !neg : link;
    cond = opcode_i == OP_BEQ ? eq :
           opcode_i == OP_BNE ? !eq :
           opcode_i == OP_BLEZ ? (neg | zero) :
           opcode_i == OP_BGTZ ? (!neg & !zero) :
           opcode_i == OP_REGIMM ? regimm : 1'b0;
  end
  assign br_o = isbr_i & cond;
endmodule

// File: rtl/id_ex_mem_pipe.sv
// id_ex_mem_pipe: D-stage branch resolve plus D/E (clr bubbles) and E/M pipeline registers; BRANCH_LINK_EN passed to branch_cmp
module id_ex_mem_pipe
  import id_ex_mem_pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [DW-1:0]     d_rd1,
  input  logic [DW-1:0]     d_rd2,
  input  logic [4:0]        d_rt,
  input  logic [5:0]        d_opcode,
  input  logic              d_isbr,
  output logic              d_br,
  input  logic [DW-1:0]     d_imm,
  input  logic [DW-1:0]     d_pc,
  input  logic [AW-1:0]     d_a3,
  input  logic [4:0]        d_shamt,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DW-1:0]     de_rd1,
  output logic [DW-1:0]     de_rd2,
  output logic [DW-1:0]     de_imm,
  output logic [DW-1:0]     de_pc,
  output logic [AW-1:0]     de_a3,
  output logic [4:0]        de_shamt,
  output logic [CTRL_W-1:0] de_ctrl,
  input  logic [DW-1:0]     e_result,
  input  logic [DW-1:0]     e_rd2,
  output logic [DW-1:0]     em_result,
  output logic [DW-1:0]     em_rd2,
  output logic [DW-1:0]     em_pc,
  output logic [AW-1:0]     em_a3,
  output logic              em_dmwe,
  output logic              em_datawbsel,
  output logic              em_regwe,
  output logic [2:0]        em_slctrl
);
  localparam int DEW = 4*DW + AW + 5 + CTRL_W;
  localparam int EMW = 3*DW + AW + 6;
  logic [DEW-1:0] de_d, de_q;
  logic [EMW-1:0] em_d, em_q;
  branch_cmp #(.DW(DW)) u_cmp (
    .rd1_i(d_rd1), .rd2_i(d_rd2), .rt_i(d_rt), .opcode_i(d_opcode), .isbr_i(d_isbr), .br_o(d_br)
  );
  assign de_d = clr ? '0 : {d_rd1, d_rd2, d_imm, d_pc, d_a3, d_shamt, d_ctrl};
  assign em_d = {e_result, e_rd2, de_pc, de_a3, de_ctrl[C_DMWE], de_ctrl[C_DATAWBSEL],
                 de_ctrl[C_REGWE], de_ctrl[C_SLCTRL +: 3]};
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q <= '0;
      em_q <= '0;
    end else begin
      de_q <= de_d;
      em_q <= em_d;
    end
  end
  assign {de_rd1, de_rd2, de_imm, de_pc, de_a3, de_shamt, de_ctrl} = de_q;
  assign {em_result, em_rd2, em_pc, em_a3, em_dmwe, em_datawbsel, em_regwe, em_slctrl} = em_q;
endmodule

// File: tb/tb_id_ex_mem_pipe.sv
// tb_id_ex_mem_pipe: directed self-checking bench for id_ex_mem_pipe
module tb_id_ex_mem_pipe;
  logic clk = 0, reset, clr;
  logic [31:0] d_rd1, d_rd2, d_imm, d_pc, e_result, e_rd2;
  logic [4:0] d_rt, d_a3, d_shamt;
  logic [5:0] d_opcode;
  logic d_isbr, d_br;
  logic [23:0] d_ctrl, de_ctrl;
  logic [31:0] de_rd1, de_rd2, de_imm, de_pc, em_result, em_rd2, em_pc;
  logic [4:0] de_a3, de_shamt, em_a3;
  logic em_dmwe, em_datawbsel, em_regwe;
  logic [2:0] em_slctrl;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  id_ex_mem_pipe dut (
    .clk(clk), .reset(reset), .clr(clr), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_rt(d_rt),
    .d_opcode(d_opcode), .d_isbr(d_isbr), .d_br(d_br), .d_imm(d_imm), .d_pc(d_pc),
    .d_a3(d_a3), .d_shamt(d_shamt), .d_ctrl(d_ctrl), .de_rd1(de_rd1), .de_rd2(de_rd2),
    .de_imm(de_imm), .de_pc(de_pc), .de_a3(de_a3), .de_shamt(de_shamt), .de_ctrl(de_ctrl),
    .e_result(e_result), .e_rd2(e_rd2), .em_result(em_result), .em_rd2(em_rd2),
    .em_pc(em_pc), .em_a3(em_a3), .em_dmwe(em_dmwe), .em_datawbsel(em_datawbsel),
    .em_regwe(em_regwe), .em_slctrl(em_slctrl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nonzero();
    d_rd1 = 32'h11; d_rd2 = 32'h22; d_imm = 32'h33; d_pc = 32'h44;
    d_a3 = 5'd7; d_shamt = 5'd3; d_ctrl = 24'hFFFFFF;
    e_result = 32'h55; e_rd2 = 32'h66;
  endtask

  task automatic test_reset();
    reset = 1; clr = 0; d_isbr = 0; d_opcode = 0; d_rt = 0;
    fill_nonzero();
    tick();
    tick();
    total++;
    if ({de_rd1, de_rd2, de_imm, de_pc, de_a3, de_shamt, de_ctrl} !== '0) begin
      bad++; $display("FAIL reset_de got=%h/%h/%h exp=0", de_pc, de_ctrl, de_imm);
    end
    total++;
    if ({em_result, em_rd2, em_pc, em_a3, em_dmwe, em_datawbsel, em_regwe, em_slctrl} !== '0) begin
      bad++; $display("FAIL reset_em got=%h/%h/%b exp=0", em_result, em_pc, em_regwe);
    end
    reset = 0;
  endtask

  task automatic br_case(input string name, input logic [5:0] op, input logic [4:0] rt,
                         input logic [31:0] a, input logic [31:0] b, input logic isbr,
                         input logic exp);
    d_opcode = op; d_rt = rt; d_rd1 = a; d_rd2 = b; d_isbr = isbr;
    #1;
    total++;
    if (d_br !== exp) begin
      bad++; $display("FAIL %s got=%b exp=%b", name, d_br, exp);
    end
  endtask

  task automatic test_branch();
    br_case("beq_eq", 6'b000100, 0, 32'h5, 32'h5, 1, 1);
    br_case("bne_eq", 6'b000101, 0, 32'h5, 32'h5, 1, 0);
    br_case("bne_ne", 6'b000101, 0, 32'h5, 32'h6, 1, 1);
    br_case("beq_ne", 6'b000100, 0, 32'h5, 32'h6, 1, 0);
    br_case("isbr0_beq", 6'b000100, 0, 32'h5, 32'h5, 0, 0);
    br_case("other_op", 6'b001000, 0, 32'h5, 32'h5, 1, 0);
  endtask

  task automatic test_signed();
    br_case("blez_min", 6'b000110, 0, 32'h80000000, 0, 1, 1);
    br_case("blez_zero", 6'b000110, 0, 32'h0, 0, 1, 1);
    br_case("blez_pos", 6'b000110, 0, 32'h1, 0, 1, 0);
    br_case("bgtz_min", 6'b000111, 0, 32'h80000000, 0, 1, 0);
    br_case("bgtz_one", 6'b000111, 0, 32'h1, 0, 1, 1);
    br_case("bgtz_zero", 6'b000111, 0, 32'h0, 0, 1, 0);
    br_case("bltz_zero", 6'b000001, 5'h00, 32'h0, 0, 1, 0);
    br_case("bltz_neg", 6'b000001, 5'h00, 32'hFFFFFFFF, 0, 1, 1);
    br_case("bgez_zero", 6'b000001, 5'h01, 32'h0, 0, 1, 1);
    br_case("bgez_neg", 6'b000001, 5'h01, 32'h80000000, 0, 1, 0);
    br_case("regimm_rt2", 6'b000001, 5'h02, 32'h0, 0, 1, 0);
`ifdef BRANCH_LINK_EN
    br_case("bltzal_neg", 6'b000001, 5'h10, 32'hFFFFFFFF, 0, 1, 1);
    br_case("bgezal_pos", 6'b000001, 5'h11, 32'h4, 0, 1, 1);
    br_case("bgezal_neg", 6'b000001, 5'h11, 32'hFFFFFFFF, 0, 1, 0);
`else
    br_case("bltzal_neg", 6'b000001, 5'h10, 32'hFFFFFFFF, 0, 1, 0);
    br_case("bgezal_pos", 6'b000001, 5'h11, 32'h4, 0, 1, 0);
`endif
    d_isbr = 0;
  endtask

  task automatic test_flow();
    clr = 0;
    d_rd1 = 32'hA1; d_rd2 = 32'hB2; d_imm = 32'h1234; d_pc = 32'h3000;
    d_a3 = 5'd9; d_shamt = 5'd4; d_ctrl = 24'h028050;
    tick();
    total++;
    if (de_imm !== 32'h1234 || de_pc !== 32'h3000 || de_ctrl !== 24'h028050) begin
      bad++; $display("FAIL flow_de got=%h/%h/%h exp=1234/3000/028050", de_imm, de_pc, de_ctrl);
    end
    total++;
    if (de_rd1 !== 32'hA1 || de_rd2 !== 32'hB2 || de_a3 !== 5'd9 || de_shamt !== 5'd4) begin
      bad++; $display("FAIL flow_de2 got=%h/%h/%h/%h exp=a1/b2/9/4", de_rd1, de_rd2, de_a3, de_shamt);
    end
    e_result = 32'hABCD; e_rd2 = 32'h77;
    d_pc = 32'h3004; d_ctrl = 24'h0; d_a3 = 5'd1;
    tick();
    total++;
    if (em_result !== 32'hABCD || em_pc !== 32'h3000 || em_regwe !== 1'b1 || em_rd2 !== 32'h77) begin
      bad++; $display("FAIL flow_em got=%h/%h/%b/%h exp=abcd/3000/1/77", em_result, em_pc, em_regwe, em_rd2);
    end
    total++;
    if (em_a3 !== 5'd9 || em_dmwe !== 1'b1 || em_datawbsel !== 1'b0 || em_slctrl !== 3'b101) begin
      bad++; $display("FAIL flow_em_ctrl got=%h/%b/%b/%b exp=9/1/0/101", em_a3, em_dmwe, em_datawbsel, em_slctrl);
    end
  endtask

  task automatic test_bubble();
    clr = 0; d_pc = 32'h4000; d_ctrl = 24'h000020; d_a3 = 5'd12;
    tick();
    clr = 1; d_ctrl = 24'hFFFFFF; d_pc = 32'h5000;
    tick();
    total++;
    if (de_ctrl !== 24'h0 || de_pc !== 32'h0 || de_a3 !== 5'd0) begin
      bad++; $display("FAIL bubble_de got=%h/%h/%h exp=0/0/0", de_ctrl, de_pc, de_a3);
    end
    total++;
    if (em_pc !== 32'h4000 || em_datawbsel !== 1'b1 || em_regwe !== 1'b0 || em_a3 !== 5'd12) begin
      bad++; $display("FAIL bubble_em got=%h/%b/%b/%h exp=4000/1/0/c", em_pc, em_datawbsel, em_regwe, em_a3);
    end
    clr = 0;
    tick();
    total++;
    if (de_ctrl !== 24'hFFFFFF || em_pc !== 32'h0 || em_datawbsel !== 1'b0) begin
      bad++; $display("FAIL bubble_after got=%h/%h/%b exp=ffffff/0/0", de_ctrl, em_pc, em_datawbsel);
    end
  endtask

  task automatic test_reset_mid();
    clr = 0; fill_nonzero();
    tick();
    tick();
    reset = 1;
    tick();
    total++;
    if ({de_rd1, de_rd2, de_imm, de_pc, de_a3, de_shamt, de_ctrl} !== '0 ||
        {em_result, em_rd2, em_pc, em_a3, em_dmwe, em_datawbsel, em_regwe, em_slctrl} !== '0) begin
      bad++; $display("FAIL reset_mid got=%h/%h/%h exp=0", de_ctrl, em_result, em_pc);
    end
    reset = 0;
    tick();
    total++;
    if (de_pc !== 32'h44 || de_ctrl !== 24'hFFFFFF || em_pc !== 32'h0) begin
      bad++; $display("FAIL reset_resume_de got=%h/%h/%h exp=44/ffffff/0", de_pc, de_ctrl, em_pc);
    end
    tick();
    total++;
    if (em_pc !== 32'h44 || em_result !== 32'h55 || em_regwe !== 1'b1 || em_slctrl !== 3'b111) begin
      bad++; $display("FAIL reset_resume_em got=%h/%h/%b/%b exp=44/55/1/111", em_pc, em_result, em_regwe, em_slctrl);
    end
  endtask

  task automatic test_reset_clr();
    fill_nonzero(); reset = 1; clr = 1;
    tick();
    total++;
    if (de_ctrl !== 24'h0 || de_pc !== 32'h0 || em_regwe !== 1'b0 || em_result !== 32'h0) begin
      bad++; $display("FAIL reset_clr got=%h/%h/%b/%h exp=0", de_ctrl, de_pc, em_regwe, em_result);
    end
    reset = 0; clr = 0;
  endtask

  task automatic test_back_to_back();
    clr = 0; d_ctrl = 24'h000050;
    tick();
    tick();
    total++;
    if (em_regwe !== 1'b1 || em_dmwe !== 1'b1) begin
      bad++; $display("FAIL b2b_pre got=%b/%b exp=1/1", em_regwe, em_dmwe);
    end
    clr = 1;
    tick();
    total++;
    if (de_ctrl !== 24'h0 || em_regwe !== 1'b1) begin
      bad++; $display("FAIL b2b_clr1 got=%h/%b exp=0/1", de_ctrl, em_regwe);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) clr = 0;
      tick();
      total++;
      if (em_regwe !== 1'b0 || em_dmwe !== 1'b0) begin
        bad++; $display("FAIL b2b_em%0d got=%b/%b exp=0/0", i, em_regwe, em_dmwe);
      end
    end
    total++;
    if (de_ctrl !== 24'h000050) begin
      bad++; $display("FAIL b2b_resume got=%h exp=000050", de_ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_signed();
    test_flow();
    test_bubble();
    test_reset_mid();
    test_reset_clr();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
